// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready handshake between the boot source (master) and the
// instruction loader (slave).
interface instr_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/instr_loader.sv
// Boot-time instruction memory writer: consumes a 16-bit word-count header and
// little-endian 32-bit words, writes them out, then releases the CPU reset.
module instr_loader #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 256,
    parameter logic [WIDTH-1:0] BASE_ADDR = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    instr_loader_if.slave    bs,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             cpu_rst,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic byte_ready_s;
    logic xfer_s;
    logic len_bad_s;
    logic last_word_s;

    assign byte_ready_s = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
    assign xfer_s       = bs.byte_valid && byte_ready_s;
    assign len_bad_s    = (len_q == 16'd0) || ({1'b0, len_q} > DEPTH_L);
    assign last_word_s  = (word_idx_q == (len_q - 16'd1));

    assign bs.byte_ready = byte_ready_s;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign cpu_rst       = cpu_rst_q;
    assign done          = done_q;
    assign error         = error_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HDR0;
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            byte_idx_q <= 2'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {WIDTH{1'b0}};
            wr_data_q  <= {WIDTH{1'b0}};
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR0: begin
                if (xfer_s) state_d = ST_HDR1;
                else        state_d = ST_HDR0;
            end
            ST_HDR1: begin
                if (xfer_s) state_d = ST_CHECK;
                else        state_d = ST_HDR1;
            end
            ST_CHECK: begin
                if (len_bad_s) state_d = ST_ERR;
                else           state_d = ST_DATA;
            end
            ST_DATA: begin
                if (xfer_s && (byte_idx_q == 2'd3)) state_d = ST_WRITE;
                else                                state_d = ST_DATA;
            end
            ST_WRITE: begin
                if (last_word_s) state_d = ST_DONE;
                else             state_d = ST_DATA;
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            // An illegal encoding parks in ERR so the CPU is never released by a corrupted state.
            default: state_d = ST_ERR;
        endcase
    end

    // Datapath updates and registered outputs, decoded from the upcoming state
    always_comb begin
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            ST_HDR0: begin
                if (xfer_s) len_d[7:0] = bs.byte_data;
                else        len_d      = len_q;
            end
            ST_HDR1: begin
                if (xfer_s) len_d[15:8] = bs.byte_data;
                else        len_d       = len_q;
            end
            ST_CHECK: begin
                word_idx_d = 16'd0;
                byte_idx_d = 2'd0;
            end
            ST_DATA: begin
                if (xfer_s) begin
                    wr_data_d[{byte_idx_q, 3'b000} +: 8] = bs.byte_data;
                    byte_idx_d                           = byte_idx_q + 2'd1;
                end else begin
                    byte_idx_d = byte_idx_q;
                end
            end
            ST_WRITE: begin
                if (!last_word_s) word_idx_d = word_idx_q + 16'd1;
                else              word_idx_d = word_idx_q;
            end
            default: begin
                len_d = len_q;
            end
        endcase

        wr_en_d = (state_d == ST_WRITE);
        if (state_d == ST_WRITE) wr_addr_d = BASE_ADDR + WIDTH'({word_idx_q, 2'b00});
        else                     wr_addr_d = wr_addr_q;
        done_d    = (state_d == ST_DONE);
        cpu_rst_d = (state_d != ST_DONE);
        error_d   = (state_d == ST_ERR);
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle reduced RISC-V core fetches from.
- Receives a byte stream over a valid/ready handshake: a 2-byte word-count header, then little-endian 32-bit instruction words.
- Writes each word to instruction memory on a one-cycle write strobe.
- Holds the CPU in reset until the whole program is written, then releases it.

Parameters:
- WIDTH, 32, instruction/data word width; only 32 is supported.
- DEPTH, 256, instruction memory capacity in words; legal word counts are 1..DEPTH.
- BASE_ADDR, 0, byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- byte_valid  in  1  source presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- wr_en  out  1  instruction memory write strobe, high for one cycle per word.
- wr_addr  out  WIDTH  byte address of the word being written.
- wr_data  out  WIDTH  instruction word being written.
- cpu_rst  out  1  reset to the pc register and the register file; high until the load completes.
- done  out  1  load completed; sticky until rst.
- error  out  1  illegal header; sticky until rst.

Behaviour:
- All outputs are registered except byte_ready, which is decoded from state.
- Reset values:
  - state=HDR0, byte_ready=1.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cpu_rst=1, done=0, error=0.
  - len=0, word_idx=0, byte_idx=0.
- Asserting rst at any time, including mid-load, aborts the load immediately and returns everything to reset values. Words already written stay in memory; the next load overwrites them.
- States and transitions:
  - HDR0 (ready=1): on transfer, len[7:0]<=byte_data; go to HDR1.
  - HDR1 (ready=1): on transfer, len[15:8]<=byte_data; go to CHECK.
  - CHECK (ready=0, one cycle): if len==0 or len>DEPTH, go to ERR. Otherwise go to DATA with word_idx=0 and byte_idx=0.
  - DATA (ready=1): on transfer, wr_data[8*byte_idx +: 8]<=byte_data and byte_idx increments. On the 4th byte (byte_idx==3), byte_idx wraps to 0 and the state goes to WRITE. The first byte received is the LSB.
  - WRITE (ready=0, one cycle): wr_en=1, wr_addr=BASE_ADDR+4*word_idx, wr_data holds the assembled word.
    - If word_idx==len-1, go to DONE.
    - Otherwise word_idx increments and the state returns to DATA.
  - DONE (ready=0): done=1, cpu_rst=0. Terminal until rst.
  - ERR (ready=0): error=1, cpu_rst=1. Terminal until rst.
- wr_en is 0 in every state except WRITE.
- wr_addr and wr_data hold their last values outside WRITE.
- done and cpu_rst deassertion change together: done rises and cpu_rst falls in the first cycle after the final wr_en cycle.
- error rises in the cycle after CHECK.
- Bytes presented while byte_ready=0 are not consumed. The source must hold them; the loader never drops or double-counts a byte.
- byte_valid gaps in any ready state stall the FSM with no state change.
- Minimum throughput is 5 cycles per word (4 DATA transfers + 1 WRITE).
- Address arithmetic is modulo 2^WIDTH; no wrap checking beyond the DEPTH check.
- len is 16 bits wide. Header values above DEPTH (up to 65535) go to ERR.

Test Plan:
- Normal load: header 02 00, then bytes 13 05 50 00 93 05 15 00 streamed with byte_valid held high. Required:
  - wr_en pulses twice, 5 cycles apart.
  - First write: wr_addr=0x0, wr_data=0x00500513.
  - Second write: wr_addr=0x4, wr_data=0x00150593.
  - cpu_rst falls and done rises in the cycle after the second pulse.
- Backpressure/gaps: same stream with byte_valid toggled randomly, with bytes held during WRITE/CHECK. Required: identical writes, no lost or duplicated byte, and done asserted.
- Zero length: header 00 00. Required: error=1 two cycles after the second header byte, no wr_en ever, cpu_rst stays 1, byte_ready=0 thereafter.
- Oversize with DEPTH=256: header 01 01 (len=257). Required: error=1, no writes. Boundary check: header 00 01 (len=256) is accepted and produces 256 writes, the last at wr_addr=0x3FC.
- Reset mid-load: assert rst after 6 payload bytes of a 2-word load. Required:
  - All outputs return to reset values asynchronously.
  - A fresh header 01 00 followed by EF BE AD DE gives one write: wr_addr=0x0, wr_data=0xDEADBEEF, then done=1.
- BASE_ADDR=0x100, header 01 00, one word. Required: wr_addr=0x100.
